mem_bus_router: RTL

- Sits directly downstream of the address translator, between the CPU load/store port and the memory targets.
- Accepts one CPU request at a time, together with the translated address and region code from the translator.
- Routes the request to the RAM port or the VGA framebuffer port, waits for the target's acknowledge, and returns read data or an error to the CPU.
- Detects unmapped regions and hung targets (timeout) and records the faulting address.

---
 rtl/mem_bus_router.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_router.sv
// Routes one CPU load/store at a time to the RAM or VGA target, waits for that
// target's acknowledge (bounded by a timeout) and returns data or an error.
module mem_bus_router #(
  parameter int WORD_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [WORD_WIDTH-1:0] cpu_addr,
  input  logic [WORD_WIDTH-1:0] cpu_wdata,
  input  logic [WORD_WIDTH-1:0] tr_addr,
  input  logic [WORD_WIDTH-1:0] tr_state,
  output logic                  cpu_ready,
  output logic [WORD_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_err,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [WORD_WIDTH-1:0] ram_addr,
  output logic [WORD_WIDTH-1:0] ram_wdata,
  input  logic                  ram_ack,
  input  logic [WORD_WIDTH-1:0] ram_rdata,
  output logic                  vga_req,
  output logic                  vga_we,
  output logic [WORD_WIDTH-1:0] vga_addr,
  output logic [WORD_WIDTH-1:0] vga_wdata,
  input  logic                  vga_ack,
  input  logic [WORD_WIDTH-1:0] vga_rdata,
  output logic [WORD_WIDTH-1:0] err_addr,
  output logic [1:0]            err_code,
  output logic [1:0]            dbg_state
);

  // Handshake: cpu_req is held until cpu_ready; cpu_ready is a one-cycle pulse
  // carrying cpu_rdata/cpu_err. A target *_req is held until that target's
  // *_ack, which carries *_rdata in the same cycle.

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RAM_WAIT = 2'd1,
    S_VGA_WAIT = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  localparam int              CW          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST    = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [WORD_WIDTH-1:0] REGION_RAM = WORD_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] REGION_VGA = WORD_WIDTH'(2);
  localparam logic [1:0]      ERR_DECODE  = 2'd1;
  localparam logic [1:0]      ERR_TIMEOUT = 2'd2;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0]   cpu_addr_q, cpu_addr_d;
  logic                    we_q, we_d;
  logic                    ram_we_q, ram_we_d;
  logic [WORD_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [WORD_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
  logic                    vga_we_q, vga_we_d;
  logic [WORD_WIDTH-1:0]   vga_addr_q, vga_addr_d;
  logic [WORD_WIDTH-1:0]   vga_wdata_q, vga_wdata_d;
  logic [WORD_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [WORD_WIDTH-1:0]   err_addr_q, err_addr_d;
  logic [1:0]              err_code_q, err_code_d;
  logic                    tmo;

  assign tmo = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cpu_addr_q  <= '0;
      we_q        <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      vga_we_q    <= 1'b0;
      vga_addr_q  <= '0;
      vga_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_addr_q  <= cpu_addr_d;
      we_q        <= we_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      vga_we_q    <= vga_we_d;
      vga_addr_q  <= vga_addr_d;
      vga_wdata_q <= vga_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      err_code_q  <= err_code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          if (tr_state == REGION_RAM)      state_d = S_RAM_WAIT;
          else if (tr_state == REGION_VGA) state_d = S_VGA_WAIT;
          else                             state_d = S_RESP;
        end
      end
      S_RAM_WAIT: if (ram_ack || tmo) state_d = S_RESP;
      S_VGA_WAIT: if (vga_ack || tmo) state_d = S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath next-values; an ack in the timeout cycle takes priority.
  always_comb begin
    cnt_d       = '0;
    cpu_addr_d  = cpu_addr_q;
    we_d        = we_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    vga_we_d    = vga_we_q;
    vga_addr_d  = vga_addr_q;
    vga_wdata_d = vga_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    err_code_d  = err_code_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          cpu_addr_d = cpu_addr;
          we_d       = cpu_we;
          if (tr_state == REGION_RAM) begin
            ram_we_d    = cpu_we;
            ram_addr_d  = tr_addr;
            ram_wdata_d = cpu_wdata;
          end else if (tr_state == REGION_VGA) begin
            vga_we_d    = cpu_we;
            vga_addr_d  = tr_addr;
            vga_wdata_d = cpu_wdata;
          end else begin
            err_d      = 1'b1;
            rdata_d    = '0;
            err_addr_d = cpu_addr;
            err_code_d = ERR_DECODE;
          end
        end
      end
      S_RAM_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (ram_ack) begin
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : ram_rdata;
        end else if (tmo) begin
          err_d      = 1'b1;
          rdata_d    = '0;
          err_addr_d = cpu_addr_q;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_VGA_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (vga_ack) begin
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : vga_rdata;
        end else if (tmo) begin
          err_d      = 1'b1;
          rdata_d    = '0;
          err_addr_d = cpu_addr_q;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_RESP: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    ram_req   = (state_q == S_RAM_WAIT);
    vga_req   = (state_q == S_VGA_WAIT);
    cpu_ready = (state_q == S_RESP);
    cpu_err   = (state_q == S_RESP) && err_q;
    cpu_rdata = rdata_q;
    ram_we    = ram_we_q;
    ram_addr  = ram_addr_q;
    ram_wdata = ram_wdata_q;
    vga_we    = vga_we_q;
    vga_addr  = vga_addr_q;
    vga_wdata = vga_wdata_q;
    err_addr  = err_addr_q;
    err_code  = err_code_q;
    dbg_state = state_q;
  end

endmodule
